// File: rtl/mini_regfile_8x.sv
// mini_regfile_8x
// Eight-entry register file for the mini MIPS datapath. Register 0 reads as
// zero and is not stored. Two combinational read ports, one synchronous write
// port, and an optional same-cycle write-to-read bypass. wr_ack pulses for one
// cycle after every accepted write.
module mini_regfile_8x #(
  parameter int DATA_W    = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        rd_addr_a,
  input  logic [2:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack
);

  // Storage for r1..r7 only; r0 is a constant zero.
  logic [DATA_W-1:0] mem_reg  [1:7];
  logic [DATA_W-1:0] mem_next [1:7];
  // Read view of all eight registers, r0 included.
  logic [DATA_W-1:0] view     [0:7];
  // One-hot write decode; bit 0 is forced low so r0 can never be written.
  logic [7:0]        wr_sel;
  logic              wr_accept;
  logic              wr_ack_reg;
  logic              byp_a;
  logic              byp_b;

  // 3-to-8 write decode, gated by the write enable.
  always_comb begin
    wr_sel          = '0;
    if (wr_en) begin
      wr_sel[wr_addr] = 1'b1;
    end
    wr_sel[0]       = 1'b0;
  end

  assign wr_accept = |wr_sel;

  assign view[0] = '0;

  // Per-register next-state: load on a decoded write, otherwise hold.
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_reg
      assign mem_next[gi] = wr_sel[gi] ? wr_data : mem_reg[gi];
      assign view[gi]     = mem_reg[gi];
    end
  endgenerate

  // Storage update; asynchronous reset clears every register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 8; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 1; i < 8; i++) begin
        mem_reg[i] <= mem_next[i];
      end
    end
  end

  // Write acknowledge: one cycle after each accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack_reg <= 1'b0;
    end else begin
      wr_ack_reg <= wr_accept;
    end
  end

  assign wr_ack = wr_ack_reg;

  // Bypass select per port. wr_sel[0] is always low, so address 0 never
  // bypasses. It is gated by rst_n because writes seen during reset are
  // discarded and reads must return zero.
  always_comb begin
    byp_a = 1'b0;
    byp_b = 1'b0;
    if (BYPASS_EN && rst_n) begin
      byp_a = wr_sel[rd_addr_a];
      byp_b = wr_sel[rd_addr_b];
    end
  end

  // Read muxes with optional forwarding of the in-flight write data.
  always_comb begin
    rd_data_a = byp_a ? wr_data : view[rd_addr_a];
    rd_data_b = byp_b ? wr_data : view[rd_addr_b];
  end

endmodule

// File: tb/tb_mini_regfile_8x.sv
// tb_mini_regfile_8x
// Directed test of mini_regfile_8x. Two instances share the same stimulus:
// one with bypass enabled and one with it disabled.
module tb_mini_regfile_8x;

  logic        clk;
  logic        rst_n;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;

  logic [31:0] byp_data_a, byp_data_b;
  logic [31:0] nob_data_a, nob_data_b;
  logic        byp_ack, nob_ack;

  int checks_total  = 0;
  int checks_passed = 0;

  mini_regfile_8x #(.DATA_W(32), .BYPASS_EN(1'b1)) u_dut_byp (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (byp_data_a),
    .rd_data_b (byp_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (byp_ack)
  );

  mini_regfile_8x #(.DATA_W(32), .BYPASS_EN(1'b0)) u_dut_nob (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (nob_data_a),
    .rd_data_b (nob_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (nob_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      checks_passed++;
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic drive(input logic en, input logic [2:0] addr, input logic [31:0] data);
    wr_en   = en;
    wr_addr = addr;
    wr_data = data;
  endtask

  // Advance past the next rising edge and let outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write address must be known whenever a write is requested.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      check("wr_addr_known", {31'b0, $isunknown(wr_addr)}, 32'h0);
    end
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp;
    rst_n     = 1'b0;
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd0;
    drive(1'b0, 3'd0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    // Reset state
    rd_addr_a = 3'd3;
    rd_addr_b = 3'd5;
    #1;
    check("reset_rd_a", byp_data_a, 32'h0);
    check("reset_rd_b", byp_data_b, 32'h0);
    check("reset_ack", {31'b0, byp_ack}, 32'h0);

    // Asynchronous reset clears contents and ack mid-cycle
    @(posedge clk); #1;
    drive(1'b1, 3'd3, 32'hDEADBEEF);
    tick();
    drive(1'b1, 3'd5, 32'hDEADBEEF);
    tick();
    drive(1'b1, 3'd5, 32'hDEADBEEF);
    check("pre_rst_ack", {31'b0, byp_ack}, 32'h1);
    check("pre_rst_r3", byp_data_a, 32'hDEADBEEF);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_rd_a_r3", byp_data_a, 32'h0);
    check("async_rst_rd_b_r5", byp_data_b, 32'h0);
    check("async_rst_ack", {31'b0, byp_ack}, 32'h0);
    tick();
    check("rst_write_discard", byp_data_b, 32'h0);
    drive(1'b0, 3'd0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic write/read with back-to-back ack
    drive(1'b1, 3'd1, 32'h12345678);
    tick();
    check("ack_wr1", {31'b0, byp_ack}, 32'h1);
    drive(1'b1, 3'd7, 32'hFFFFFFFF);
    tick();
    check("ack_wr2", {31'b0, byp_ack}, 32'h1);
    drive(1'b0, 3'd0, 32'h0);
    rd_addr_a = 3'd1;
    rd_addr_b = 3'd7;
    #1;
    check("read_r1", byp_data_a, 32'h12345678);
    check("read_r7", byp_data_b, 32'hFFFFFFFF);
    tick();
    check("ack_idle", {31'b0, byp_ack}, 32'h0);

    // r0 cannot be written and never bypasses
    rd_addr_a = 3'd0;
    drive(1'b1, 3'd0, 32'hA5A5A5A5);
    #1;
    check("r0_before_edge", byp_data_a, 32'h0);
    tick();
    check("r0_after_edge", byp_data_a, 32'h0);
    check("r0_nob_after", nob_data_a, 32'h0);
    check("r0_ack", {31'b0, byp_ack}, 32'h0);

    // Bypass behaviour on both variants
    drive(1'b1, 3'd4, 32'h11111111);
    tick();
    drive(1'b1, 3'd4, 32'h22222222);
    rd_addr_a = 3'd4;
    rd_addr_b = 3'd4;
    #1;
    check("byp_a_same_cycle", byp_data_a, 32'h22222222);
    check("byp_b_same_cycle", byp_data_b, 32'h22222222);
    check("nob_a_pre_edge", nob_data_a, 32'h11111111);
    check("nob_b_pre_edge", nob_data_b, 32'h11111111);
    tick();
    drive(1'b0, 3'd0, 32'h0);
    #1;
    check("nob_a_post_edge", nob_data_a, 32'h22222222);
    check("nob_b_post_edge", nob_data_b, 32'h22222222);
    check("byp_a_post_edge", byp_data_a, 32'h22222222);

    // Write disabled: no store, no ack, no bypass
    drive(1'b0, 3'd2, 32'h0BADF00D);
    rd_addr_a = 3'd2;
    rd_addr_b = 3'd2;
    #1;
    check("wdis_byp_a", byp_data_a, 32'h0);
    check("wdis_byp_b", byp_data_b, 32'h0);
    tick();
    check("wdis_r2", byp_data_a, 32'h0);
    check("wdis_ack", {31'b0, byp_ack}, 32'h0);

    // Sweep: ri = i * 0x01010101, then read every address on both ports
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 3'(i), 32'(i) * 32'h01010101);
      tick();
    end
    drive(1'b0, 3'd0, 32'h0);
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a);
      rd_addr_b = 3'(a);
      #1;
      exp = 32'(a) * 32'h01010101;
      check($sformatf("sweep_a_r%0d", a), byp_data_a, exp);
      check($sformatf("sweep_b_r%0d", a), byp_data_b, exp);
      check($sformatf("sweep_nob_r%0d", a), nob_data_a, exp);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
